// File: rtl/pc_sequencer_if.sv
// Control and status bundle for pc_sequencer.
// master drives control and LUT writes; slave is the sequencer.
interface pc_sequencer_if #(
  parameter int D  = 12,
  parameter int LW = 4
);
  logic          start;
  logic          stall;
  logic          halt;
  logic          branch_en;
  logic          call_en;
  logic [1:0]    imm_or_lut;
  logic [LW-1:0] sel;
  logic          lut_we;
  logic [LW-1:0] lut_waddr;
  logic [D-1:0]  lut_wdata;
  logic [D-1:0]  pc;
  logic          done;
  logic          err;

  modport master (
    output start, stall, halt, branch_en, call_en,
    output imm_or_lut, sel,
    output lut_we, lut_waddr, lut_wdata,
    input  pc, done, err
  );

  modport slave (
    input  start, stall, halt, branch_en, call_en,
    input  imm_or_lut, sel,
    input  lut_we, lut_waddr, lut_wdata,
    output pc, done, err
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter sequencer: branch-target LUT and optional return stack.
// Define PC_SEQUENCER_RAS_EN to build the return-address stack and err flag.
module pc_sequencer #(
  parameter int D         = 12,
  parameter int LUT_DEPTH = 16,
  parameter int RAS_DEPTH = 4
) (
  input logic          clk,
  input logic          reset_n,
  pc_sequencer_if.slave bus
);
  localparam int LW = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1;

  typedef enum logic [1:0] {
    M_REL_IMM = 2'b00,
    M_REL_LUT = 2'b01,
    M_ABS_LUT = 2'b10,
    M_RET     = 2'b11
  } mode_e;

  logic [D-1:0] pc_q, pc_d;
  logic         done_q, done_d;
  logic [D-1:0] lut_q [LUT_DEPTH];
  logic [D-1:0] lut_rd;
  logic [D-1:0] sext;
  logic [D-1:0] pc_inc;
  logic [D-1:0] tgt;
  logic         taken;

  assign pc_inc = pc_q + 1'b1;
  assign sext   = {{(D-LW){bus.sel[LW-1]}}, bus.sel};
  assign taken  = bus.branch_en | bus.call_en;

  // LUT is read from the registers, so a same-cycle write is not seen
  assign lut_rd = (32'(bus.sel) < LUT_DEPTH) ? lut_q[bus.sel] : '0;

  always_comb begin
    unique case (mode_e'(bus.imm_or_lut))
      M_REL_IMM: tgt = pc_q + sext;
      M_REL_LUT: tgt = pc_q + lut_rd;
      M_ABS_LUT: tgt = lut_rd;
      default:   tgt = pc_inc;
    endcase
  end

`ifdef PC_SEQUENCER_RAS_EN
  localparam int SW = $clog2(RAS_DEPTH + 1);
  localparam int RW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [SW-1:0] FULL = SW'(RAS_DEPTH);

  logic [D-1:0]  ras_q [RAS_DEPTH];
  logic [SW-1:0] sp_q, sp_d;
  logic          err_q, err_d;
  logic          push;
  logic [RW-1:0] top_idx;
  logic [RW-1:0] push_idx;

  assign top_idx  = RW'(sp_q - 1'b1);
  assign push_idx = RW'(sp_q);
`endif

  always_comb begin
    pc_d   = pc_q;
    done_d = done_q;
`ifdef PC_SEQUENCER_RAS_EN
    sp_d   = sp_q;
    err_d  = err_q;
    push   = 1'b0;
`endif
    if (bus.start) begin
      pc_d   = '0;
      done_d = 1'b0;
    end else if (done_q || bus.stall) begin
      pc_d = pc_q;
    end else if (bus.halt) begin
      done_d = 1'b1;
    end else if (taken) begin
`ifdef PC_SEQUENCER_RAS_EN
      if (mode_e'(bus.imm_or_lut) == M_RET) begin
        if (sp_q == '0) begin
          err_d = 1'b1;
          pc_d  = pc_inc;
        end else begin
          pc_d = ras_q[top_idx];
          sp_d = sp_q - 1'b1;
        end
      end else begin
        pc_d = tgt;
        // a full stack drops the push but the call still branches
        if (bus.call_en) begin
          if (sp_q == FULL) begin
            err_d = 1'b1;
          end else begin
            push = 1'b1;
            sp_d = sp_q + 1'b1;
          end
        end
      end
`else
      pc_d = tgt;
`endif
    end else begin
      pc_d = pc_inc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q   <= '0;
      done_q <= 1'b0;
      for (int i = 0; i < LUT_DEPTH; i++) begin
        lut_q[i] <= '0;
      end
    end else begin
      pc_q   <= pc_d;
      done_q <= done_d;
      if (bus.lut_we && (32'(bus.lut_waddr) < LUT_DEPTH)) begin
        lut_q[bus.lut_waddr] <= bus.lut_wdata;
      end
    end
  end

`ifdef PC_SEQUENCER_RAS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp_q  <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= '0;
      end
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
      if (push) begin
        ras_q[push_idx] <= pc_inc;
      end
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.pc   = pc_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer with a reference-model scoreboard.
// Expectations follow PC_SEQUENCER_RAS_EN in the same way as the design.
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

`ifdef PC_SEQUENCER_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  pc_sequencer_if #(.D(12), .LW(4)) bus();

  pc_sequencer #(
    .D(12),
    .LUT_DEPTH(16),
    .RAS_DEPTH(4)
  ) u_dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int errs = 0;
  int checks = 0;

  logic [11:0] m_pc;
  logic        m_done;
  logic        m_err;
  logic [11:0] m_lut [16];
  logic [11:0] m_ras [$];
  logic [13:0] sb_q [$];
  logic [11:0] p0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc   = '0;
    m_done = 1'b0;
    m_err  = 1'b0;
    m_ras.delete();
    for (int i = 0; i < 16; i++) m_lut[i] = '0;
  endtask

  task automatic model_step();
    logic [11:0] lrd, sx, tg, nx;
    lrd = m_lut[bus.sel];
    sx  = {{8{bus.sel[3]}}, bus.sel};
    nx  = m_pc + 12'd1;
    case (bus.imm_or_lut)
      2'b00:   tg = m_pc + sx;
      2'b01:   tg = m_pc + lrd;
      2'b10:   tg = lrd;
      default: tg = nx;
    endcase
    if (bus.start) begin
      m_pc   = '0;
      m_done = 1'b0;
    end else if (m_done || bus.stall) begin
      m_pc = m_pc;
    end else if (bus.halt) begin
      m_done = 1'b1;
    end else if (bus.branch_en || bus.call_en) begin
      if (RAS && bus.imm_or_lut == 2'b11) begin
        if (m_ras.size() == 0) begin
          m_err = 1'b1;
          m_pc  = nx;
        end else begin
          m_pc = m_ras.pop_back();
        end
      end else begin
        if (RAS && bus.call_en) begin
          if (m_ras.size() == 4) m_err = 1'b1;
          else m_ras.push_back(nx);
        end
        m_pc = tg;
      end
    end else begin
      m_pc = nx;
    end
    if (bus.lut_we) m_lut[bus.lut_waddr] = bus.lut_wdata;
  endtask

  task automatic drive(input logic st, input logic stl, input logic hlt,
                       input logic br, input logic cl,
                       input logic [1:0] md, input logic [3:0] s,
                       input logic we, input logic [3:0] wa,
                       input logic [11:0] wd);
    bus.start      = st;
    bus.stall      = stl;
    bus.halt       = hlt;
    bus.branch_en  = br;
    bus.call_en    = cl;
    bus.imm_or_lut = md;
    bus.sel        = s;
    bus.lut_we     = we;
    bus.lut_waddr  = wa;
    bus.lut_wdata  = wd;
  endtask

  task automatic run();
    logic [13:0] e;
    model_step();
    sb_q.push_back({m_pc, m_done, m_err});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("sb_pc", bus.pc, e[13:2]);
    chk("sb_done", bus.done, e[1]);
    chk("sb_err", bus.err, e[0]);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 2'b00, 4'd0, 0, 4'd0, 12'd0);
    run();
  endtask

  task automatic branch(input logic [1:0] md, input logic [3:0] s);
    drive(0, 0, 0, 1, 0, md, s, 0, 4'd0, 12'd0);
    run();
  endtask

  task automatic callx(input logic [1:0] md, input logic [3:0] s);
    drive(0, 0, 0, 0, 1, md, s, 0, 4'd0, 12'd0);
    run();
  endtask

  task automatic lutw(input logic [3:0] a, input logic [11:0] d);
    drive(0, 0, 0, 0, 0, 2'b00, 4'd0, 1, a, d);
    run();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    drive(0, 0, 0, 0, 0, 2'b00, 4'd0, 0, 4'd0, 12'd0);
    reset_n = 1'b0;
    model_reset();
    #12;
    chk("rst_pc", bus.pc, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    reset_n = 1'b1;

    for (int i = 1; i <= 5; i++) begin
      idle();
      chk("idle_pc", bus.pc, i);
    end
    for (int i = 0; i < 5; i++) idle();
    chk("at10", bus.pc, 10);
    branch(2'b00, 4'b1011);
    chk("rel_neg", bus.pc, 5);

    lutw(4'd5, 12'hFFF);
    branch(2'b10, 4'd5);
    chk("abs_max", bus.pc, 12'hFFF);
    idle();
    chk("wrap", bus.pc, 0);

    drive(0, 0, 0, 1, 0, 2'b10, 4'd3, 1, 4'd3, 12'h123);
    run();
    chk("lut_prewr", bus.pc, 0);
    branch(2'b10, 4'd3);
    chk("lut_abs", bus.pc, 12'h123);

    lutw(4'd4, 12'hFFE);
    branch(2'b01, 4'd4);
    chk("lut_rel", bus.pc, 12'h122);

    lutw(4'd6, 12'd20);
    branch(2'b10, 4'd6);
    chk("to20", bus.pc, 20);
    callx(2'b00, 4'd5);
    chk("call_pc", bus.pc, 25);
    for (int i = 0; i < 5; i++) idle();
    branch(2'b11, 4'd0);
    chk("ret_pc", bus.pc, RAS ? 21 : 31);
    branch(2'b11, 4'd0);
    chk("uflow_pc", bus.pc, RAS ? 22 : 32);
    chk("uflow_err", bus.err, RAS ? 1 : 0);

    p0 = m_pc;
    drive(0, 1, 0, 1, 0, 2'b10, 4'd6, 1, 4'd7, 12'h200);
    run();
    chk("stall_hold", bus.pc, p0);
    branch(2'b10, 4'd7);
    chk("stall_lutwr", bus.pc, 12'h200);

    #2;
    drive(0, 1, 0, 0, 0, 2'b00, 4'd0, 0, 4'd0, 12'd0);
    reset_n = 1'b0;
    #1;
    chk("arst_pc", bus.pc, 0);
    chk("arst_err", bus.err, 0);
    model_reset();
    #1;
    reset_n = 1'b1;
    branch(2'b10, 4'd7);
    chk("lut_clr", bus.pc, 0);

    for (int i = 1; i <= 5; i++) begin
      callx(2'b00, 4'd2);
      chk("nest_pc", bus.pc, 2 * i);
      chk("nest_err", bus.err, (RAS && i == 5) ? 1 : 0);
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 3) callx(2'b11, 4'd0);
      else branch(2'b11, 4'd0);
      chk("lifo_pc", bus.pc, RAS ? (7 - 2 * i) : (11 + i));
    end

    lutw(4'd9, 12'd7);
    branch(2'b10, 4'd9);
    chk("to7", bus.pc, 7);
    drive(0, 0, 1, 1, 0, 2'b00, 4'd1, 0, 4'd0, 12'd0);
    run();
    chk("halt_done", bus.done, 1);
    chk("halt_pc", bus.pc, 7);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, i[0], 1, i[1], 2'b10, 4'd5, 0, 4'd0, 12'd0);
      run();
      chk("done_hold", bus.pc, 7);
    end
    drive(1, 1, 1, 1, 1, 2'b10, 4'd9, 0, 4'd0, 12'd0);
    run();
    chk("start_pc", bus.pc, 0);
    chk("start_done", bus.done, 0);
    idle();
    idle();
    drive(0, 0, 1, 0, 0, 2'b00, 4'd0, 0, 4'd0, 12'd0);
    run();
    chk("halt2_done", bus.done, 1);

    #2;
    drive(0, 0, 0, 0, 0, 2'b00, 4'd0, 0, 4'd0, 12'd0);
    reset_n = 1'b0;
    #1;
    chk("arst2_pc", bus.pc, 0);
    chk("arst2_done", bus.done, 0);
    model_reset();
    #1;
    reset_n = 1'b1;
    idle();
    chk("run_after_rst", bus.pc, 1);

    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 5) == 0, 2'($urandom), 4'($urandom),
            $urandom_range(0, 3) == 0, 4'($urandom), 12'($urandom));
      run();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
